// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU load/store path and a loader/debug master.
// Define DMEM_ARB_STARVE_EN to enable the loader starvation guard (forced bounded bursts).
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [15:0]       stall_cnt
);

    logic        cpu_gnt_raw;
    logic        ld_gnt_raw;
    logic [15:0] stall_cnt_q;

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
    localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);

    typedef enum logic {StCpu, StLd} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [BeatW-1:0] beat_q, beat_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StCpu;
            wait_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        cpu_gnt_raw = 1'b0;
        ld_gnt_raw  = 1'b0;
        unique case (state_q)
            StCpu: begin
                cpu_gnt_raw = cpu_req;
                ld_gnt_raw  = ld_req & ~cpu_req;
                if (ld_req && !ld_gnt_raw) begin
                    // Denied for MAX_WAIT consecutive cycles: hand the port to the loader.
                    if (wait_q == WaitLast) begin
                        state_d = StLd;
                        wait_d  = '0;
                        beat_d  = '0;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            StLd: begin
                ld_gnt_raw = ld_req;
                wait_d     = '0;
                if (!ld_req || beat_q == BeatLast) begin
                    state_d = StCpu;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BeatW'(1);
                end
            end
            default: state_d = StCpu;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_gnt_raw & reset;
`else
    assign cpu_gnt_raw = cpu_req;
    assign ld_gnt_raw  = ld_req & ~cpu_req;
    assign cpu_stall   = 1'b0;
`endif

    // Grants are forced low while reset is asserted so no access can reach memory.
    assign cpu_gnt = cpu_gnt_raw & reset;
    assign ld_gnt  = ld_gnt_raw & reset;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign ld_rdata  = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (cpu_stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory behind the shared port.
// Starvation-guard scenarios run when DMEM_ARB_STARVE_EN is defined, strict priority otherwise.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_gnt, cpu_stall, ld_gnt, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, cpu_rdata, ld_rdata;
    logic [15:0] stall_cnt;

    logic [31:0] mem [0:255];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[9:2]];

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_rdata (cpu_rdata),
        .ld_rdata  (ld_rdata),
        .stall_cnt (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cdata, input logic lreq, input logic lwe,
                         input logic [31:0] laddr, input logic [31:0] ldata);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cdata;
        ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = ldata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'd100, 32'd9, 1'b1, 1'b1, 32'd96, 32'd3);
        #1;
        total_cnt++;
        if (cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt got %b want 0", cpu_gnt);
        else pass_cnt++;
        total_cnt++;
        if (ld_gnt !== 1'b0) $display("FAIL reset_ld_gnt got %b want 0", ld_gnt);
        else pass_cnt++;
        total_cnt++;
        if (mem_we !== 1'b0 || mem_addr !== 32'd0)
            $display("FAIL reset_mem got we=%b addr=%0d want we=0 addr=0", mem_we, mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (cpu_stall !== 1'b0 || stall_cnt !== 16'd0)
            $display("FAIL reset_stall got stall=%b cnt=%0d want 0 0", cpu_stall, stall_cnt);
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        #1;
        drive(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        total_cnt++;
        if (cpu_gnt !== 1'b1) $display("FAIL reset_release_cpu_gnt got %b want 1", cpu_gnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_cpu_only();
        drive(1'b1, 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        total_cnt++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd100 || mem_wdata !== 32'd25)
            $display("FAIL cpu_write got gnt=%b we=%b addr=%0d data=%0d want 1 1 100 25",
                     cpu_gnt, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if (ld_gnt !== 1'b0 || cpu_stall !== 1'b0)
            $display("FAIL cpu_write_side got ld_gnt=%b stall=%b want 0 0", ld_gnt, cpu_stall);
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        total_cnt++;
        if (cpu_rdata !== 32'd25 || mem_we !== 1'b0)
            $display("FAIL cpu_read got rdata=%0d we=%b want 25 0", cpu_rdata, mem_we);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_loader_only();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd96, 32'd7);
        #1;
        total_cnt++;
        if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd96 || mem_wdata !== 32'd7)
            $display("FAIL ld_write got gnt=%b we=%b addr=%0d data=%0d want 1 1 96 7",
                     ld_gnt, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b0)
            $display("FAIL ld_write_side got cpu_gnt=%b stall=%b want 0 0", cpu_gnt, cpu_stall);
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd96, 32'd0);
        #1;
        total_cnt++;
        if (ld_rdata !== 32'd7 || mem_we !== 1'b0)
            $display("FAIL ld_read got rdata=%0d we=%b want 7 0", ld_rdata, mem_we);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_idle();
        drive(1'b0, 1'b1, 32'd44, 32'd55, 1'b0, 1'b1, 32'd66, 32'd77);
        #1;
        total_cnt++;
        if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || cpu_gnt !== 1'b0 ||
            ld_gnt !== 1'b0)
            $display("FAIL idle_mux got we=%b addr=%0d data=%0d cg=%b lg=%b want all 0",
                     mem_we, mem_addr, mem_wdata, cpu_gnt, ld_gnt);
        else pass_cnt++;
        tick();
    endtask

`ifdef DMEM_ARB_STARVE_EN
    task automatic test_contention();
        logic [15:0] base;
        logic        exp_ld;
        base = stall_cnt;
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0, 32'd200, 32'd0, 1'b1, 1'b1, 32'd300, 32'h55);
            #1;
            exp_ld = (c == 4 || c == 5);
            total_cnt++;
            if (cpu_gnt !== !exp_ld || ld_gnt !== exp_ld || cpu_stall !== exp_ld)
                $display("FAIL contention_c%0d got cg=%b lg=%b st=%b want cg=%b lg=%b st=%b",
                         c, cpu_gnt, ld_gnt, cpu_stall, !exp_ld, exp_ld, exp_ld);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (stall_cnt !== base + 16'd2)
            $display("FAIL contention_stall_cnt got %0d want %0d", stall_cnt, base + 16'd2);
        else pass_cnt++;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_ld_drop();
        logic [15:0] base;
        base = stall_cnt;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 32'd200, 32'd0, 1'b1, 1'b0, 32'd300, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 32'd200, 32'd0, 1'b0, 1'b0, 32'd300, 32'd0);
        #1;
        total_cnt++;
        if (cpu_gnt !== 1'b0 || ld_gnt !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL drop_cycle got cg=%b lg=%b we=%b want 0 0 0", cpu_gnt, ld_gnt, mem_we);
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 32'd200, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        total_cnt++;
        if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0)
            $display("FAIL drop_next got cg=%b st=%b want 1 0", cpu_gnt, cpu_stall);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== base + 16'd1)
            $display("FAIL drop_stall_cnt got %0d want %0d", stall_cnt, base + 16'd1);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 32'd200, 32'd0, 1'b1, 1'b1, 32'd300, 32'hAA);
            tick();
        end
        total_cnt++;
        if (ld_gnt !== 1'b1 || mem_we !== 1'b1)
            $display("FAIL burst_entry got lg=%b we=%b want 1 1", ld_gnt, mem_we);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0 || ld_gnt !== 1'b0 || cpu_stall !== 1'b0 || stall_cnt !== 16'd0)
            $display("FAIL burst_reset got we=%b lg=%b st=%b cnt=%0d want 0 0 0 0",
                     mem_we, ld_gnt, cpu_stall, stall_cnt);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (cpu_gnt !== 1'b1 || ld_gnt !== 1'b0 || stall_cnt !== 16'd0)
            $display("FAIL burst_release got cg=%b lg=%b cnt=%0d want 1 0 0",
                     cpu_gnt, ld_gnt, stall_cnt);
        else pass_cnt++;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask
`else
    task automatic test_strict_priority();
        int bad_ld = 0;
        int bad_stall = 0;
        int bad_cpu = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, c[0], 32'd8, 32'd1, 1'b1, 1'b1, 32'd12, 32'd2);
            #1;
            if (ld_gnt !== 1'b0) bad_ld++;
            if (cpu_stall !== 1'b0) bad_stall++;
            if (cpu_gnt !== 1'b1 || mem_addr !== 32'd8) bad_cpu++;
            tick();
        end
        total_cnt++;
        if (bad_ld != 0) $display("FAIL strict_ld_gnt got %0d grants want 0", bad_ld);
        else pass_cnt++;
        total_cnt++;
        if (bad_stall != 0) $display("FAIL strict_stall got %0d stalls want 0", bad_stall);
        else pass_cnt++;
        total_cnt++;
        if (bad_cpu != 0) $display("FAIL strict_cpu got %0d misses want 0", bad_cpu);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd0) $display("FAIL strict_stall_cnt got %0d want 0", stall_cnt);
        else pass_cnt++;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd12, 32'd0);
        #1;
        total_cnt++;
        if (ld_gnt !== 1'b1) $display("FAIL strict_ld_after got %b want 1", ld_gnt);
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_only();
        test_loader_only();
        test_idle();
`ifdef DMEM_ARB_STARVE_EN
        test_contention();
        test_ld_drop();
        test_reset_mid_burst();
`else
        test_strict_priority();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter for the single-cycle core's data memory. It shares the one data-memory port between the CPU load/store path and a secondary loader/debug master. The CPU has default priority, and a loader starved for too long gets a bounded burst. The block sits between the core's DataAddr/WriteData/MemWrite outputs and the data memory, and returns a stall to the core's PC-enable logic.

## Interface
- ADDR_W, 32, address width (byte address, word aligned)
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive denied loader cycles before a forced loader burst (≥1)
- BURST_LEN, 2, maximum loader beats per forced burst (≥1)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU store (MemWrite)
- cpu_addr  in  ADDR_W  CPU address (DataAddr)
- cpu_wdata  in  DATA_W  CPU store data (WriteData)
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the PC
- ld_req, ld_we  in  1 each  loader request / store
- ld_addr  in  ADDR_W; ld_wdata  in  DATA_W  loader address / data
- ld_gnt  out  1  loader access performed this cycle
- mem_we  out  1  data memory write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory address / data
- mem_rdata  in  DATA_W  asynchronous read data from memory
- cpu_rdata, ld_rdata  out  DATA_W  both driven by mem_rdata, valid when the matching gnt is 1
- stall_cnt  out  16  saturating count of cpu_stall cycles

## Operation
- Registered state: fsm ∈ {S_CPU, S_LD}, wait_cnt, beat_cnt, stall_cnt.
- Grants, mux and stall are combinational from the current state and requests.
- S_CPU: cpu_gnt=cpu_req; ld_gnt=ld_req & ~cpu_req.
- S_LD: ld_gnt=ld_req; cpu_gnt=0.
- Memory mux:
  - cpu_gnt=1: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we.
  - ld_gnt=1: the same fields come from the loader port.
  - Neither granted: mem_addr=0, mem_wdata=0, mem_we=0.
  - cpu_gnt and ld_gnt are never both 1.
- wait_cnt:
  - Increments on each cycle with ld_req=1 and ld_gnt=0.
  - Clears on any cycle with ld_gnt=1 or ld_req=0.
- S_CPU → S_LD when ld_req=1, ld_gnt=0 and wait_cnt==MAX_WAIT-1, i.e. the loader has been denied MAX_WAIT consecutive cycles. On entry, wait_cnt and beat_cnt are set to 0.
- S_LD: beat_cnt increments on each granted beat.
- S_LD → S_CPU when:
  - ld_req=0 (beat_cnt cleared), or
  - ld_gnt=1 and beat_cnt==BURST_LEN-1.
- stall_cnt increments when cpu_stall=1 and saturates at 16'hFFFF.
- Reset low (asynchronous):
  - fsm=S_CPU; wait_cnt=0, beat_cnt=0, stall_cnt=0.
  - cpu_gnt=0, ld_gnt=0, mem_we=0, mem_addr=0, cpu_stall=0 for as long as reset is low.
  - Reset mid-burst aborts the burst; no memory write occurs while reset is low.

## Timing
- Zero-latency path: a granted access reaches mem_* in the same cycle. The write commits at the next clk edge inside memory.
- Read data returns combinationally in the same cycle.
- Starvation bound: a continuously requesting loader is granted no later than its (MAX_WAIT+1)-th request cycle.
- CPU stall bound: the CPU stalls at most BURST_LEN consecutive cycles per forced burst.
- Simultaneous requests in S_CPU below threshold: the CPU wins.
- Loader dropping ld_req in S_LD: the CPU is granted in the following cycle.
- First cycle after reset release: fsm=S_CPU, so a CPU request is granted immediately.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - Starvation guard as above: wait_cnt, beat_cnt and the S_LD state are present.
- Not defined:
  - Strict CPU priority: the FSM stays in S_CPU; ld_gnt=ld_req & ~cpu_req.
  - wait_cnt, beat_cnt and S_LD are not implemented; cpu_stall is constantly 0.
  - stall_cnt holds 0.

## Test plan
- CPU only: cpu_req=1, cpu_we=1, cpu_addr=100, cpu_wdata=25 → the same cycle shows cpu_gnt=1, mem_we=1, mem_addr=100, mem_wdata=25; the next cycle's read of 100 returns 25.
- Loader only: ld_req=1, ld_we=1, ld_addr=96, ld_wdata=7 → ld_gnt=1, mem_addr=96, mem_we=1, cpu_stall=0.
- Contention with defaults and both requesting continuously → cycles 0–3 cpu_gnt=1, cycles 4–5 ld_gnt=1 with cpu_stall=1, cycle 6 cpu_gnt=1; stall_cnt=2.
- Loader drops ld_req after 1 beat in S_LD → the next cycle has fsm=S_CPU and cpu_gnt=1; stall_cnt increments by 1 only.
- reset driven low during the S_LD burst with ld_we=1 → mem_we=0 immediately; after release fsm=S_CPU, stall_cnt=0, cpu_gnt follows cpu_req.
- DMEM_ARB_STARVE_EN undefined with both requesting 20 cycles → ld_gnt never 1, cpu_stall always 0.
